// File: rtl/write_address_counter.sv
// Write-side address counter: 15-entry one-hot ring pointer with occupancy tracking.
// Define WRITE_OVERFLOW_FLAG_EN to build the sticky write-while-full Overflow flag.
module write_address_counter #(
  parameter int Init = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       WriteEn,
  input  logic       ReadEn,
  output logic [3:0] WriteReg,
  output logic       WriteAccept,
  output logic [3:0] Count,
  output logic       Full,
  output logic       Empty,
  output logic       Overflow
);

  localparam logic [14:0] INIT_ONEHOT = 15'(1) << Init;

  logic [14:0] wr_ptr_reg, wr_ptr_next, wr_ptr_rot;
  logic [3:0]  count_reg, count_next;
  logic        read_accept;

  assign Full        = (count_reg == 4'd15);
  assign Empty       = (count_reg == 4'd0);
  assign Count       = count_reg;
  assign WriteAccept = WriteEn & ~Full;
  assign read_accept = ReadEn & ~Empty;

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_rot
      assign wr_ptr_rot[gi] = wr_ptr_reg[(gi + 14) % 15];
    end
  endgenerate

  // An all-zero pointer is a corrupted state; it recovers to Init on the next edge.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (wr_ptr_reg == '0)
      wr_ptr_next = INIT_ONEHOT;
    else if (WriteAccept)
      wr_ptr_next = wr_ptr_rot;
  end

  always_comb begin
    count_next = count_reg;
    case ({WriteAccept, read_accept})
      2'b10:   count_next = count_reg + 4'd1;
      2'b01:   count_next = count_reg - 4'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    WriteReg = '0;
    for (int i = 0; i < 15; i++)
      if (wr_ptr_reg[i]) WriteReg = WriteReg | 4'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= INIT_ONEHOT;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

`ifdef WRITE_OVERFLOW_FLAG_EN
  logic overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow_reg <= 1'b0;
    else if (WriteEn && Full)
      overflow_reg <= 1'b1;
  end

  assign Overflow = overflow_reg;
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_address_counter.sv
// Bench for write_address_counter: directed scenarios plus randomized traffic
// compared against an arithmetic occupancy/address model.
module tb_write_address_counter;

`ifdef WRITE_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       WriteEn, ReadEn;
  logic [3:0] WriteReg, Count;
  logic       WriteAccept, Full, Empty, Overflow;

  logic       we14, re14;
  logic [3:0] wreg14, count14;
  logic       wacc14, full14, empty14, ovf14;

  int checks = 0;
  int passes = 0;

  // Reference model: occupancy and address as plain integers.
  int m_count;
  int m_addr;
  bit m_ovf;

  always #5 clk = ~clk;

  write_address_counter #(.Init(0)) dut (
    .clk(clk), .rst_n(rst_n), .WriteEn(WriteEn), .ReadEn(ReadEn),
    .WriteReg(WriteReg), .WriteAccept(WriteAccept), .Count(Count),
    .Full(Full), .Empty(Empty), .Overflow(Overflow)
  );

  write_address_counter #(.Init(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .WriteEn(we14), .ReadEn(re14),
    .WriteReg(wreg14), .WriteAccept(wacc14), .Count(count14),
    .Full(full14), .Empty(empty14), .Overflow(ovf14)
  );

  task automatic model_reset();
    m_count = 0;
    m_addr  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit we, input bit re);
    bit wr, rd;
    wr = we && (m_count < 15);
    rd = re && (m_count > 0);
    if (we && m_count == 15) m_ovf = OVF_EN;
    m_count = m_count + int'(wr) - int'(rd);
    if (wr) m_addr = (m_addr + 1) % 15;
  endtask

  // Drive inputs for one clock, advance the model, settle 1 time unit past the edge.
  task automatic cycle(input bit we, input bit re);
    WriteEn = we;
    ReadEn  = re;
    @(posedge clk);
    model_step(we, re);
    #1;
  endtask

  task automatic do_reset();
    WriteEn = 1'b0;
    ReadEn  = 1'b0;
    rst_n   = 1'b0;
    #3;
    rst_n   = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; WriteEn = 1'b0; ReadEn = 1'b0; we14 = 1'b0; re14 = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({WriteReg, Count, Full, Empty, Overflow} !== {4'd0, 4'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state: got wreg=%0d cnt=%0d full=%b empty=%b ovf=%b, want 0/0/0/1/0",
               WriteReg, Count, Full, Empty, Overflow);
    else passes++;
    WriteEn = 1'b1;
    #1;
    checks++;
    if (WriteAccept !== 1'b1) $display("FAIL reset_accept: got %b want 1", WriteAccept);
    else passes++;
    WriteEn = 1'b0;
    #1;
    checks++;
    if (WriteAccept !== 1'b0) $display("FAIL reset_accept_low: got %b want 0", WriteAccept);
    else passes++;
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset released: wreg=%0d cnt=%0d", WriteReg, Count);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 15; i++) begin
      WriteEn = 1'b1;
      #1;
      checks++;
      if (WriteReg !== 4'(i) || WriteAccept !== 1'b1)
        $display("FAIL fill_addr[%0d]: got wreg=%0d acc=%b want wreg=%0d acc=1", i, WriteReg, WriteAccept, i);
      else passes++;
      cycle(1'b1, 1'b0);
    end
    checks++;
    if (Count !== 4'd15 || Full !== 1'b1 || WriteReg !== 4'd0)
      $display("FAIL fill_end: got cnt=%0d full=%b wreg=%0d want 15/1/0", Count, Full, WriteReg);
    else passes++;
    $display("fill: cnt=%0d full=%b wreg=%0d", Count, Full, WriteReg);
  endtask

  task automatic test_full_write();
    for (int i = 0; i < 3; i++) begin
      WriteEn = 1'b1;
      #1;
      checks++;
      if (WriteAccept !== 1'b0) $display("FAIL full_accept[%0d]: got %b want 0", i, WriteAccept);
      else passes++;
      cycle(1'b1, 1'b0);
    end
    checks++;
    if (WriteReg !== 4'd0 || Count !== 4'd15 || Overflow !== m_ovf)
      $display("FAIL full_hold: got wreg=%0d cnt=%0d ovf=%b want 0/15/%b", WriteReg, Count, Overflow, m_ovf);
    else passes++;
    $display("full write x3: wreg=%0d cnt=%0d ovf=%b", WriteReg, Count, Overflow);
  endtask

  task automatic test_full_both();
    cycle(1'b1, 1'b1);
    checks++;
    if (Count !== 4'd14 || Full !== 1'b0 || WriteReg !== 4'd0)
      $display("FAIL full_both1: got cnt=%0d full=%b wreg=%0d want 14/0/0", Count, Full, WriteReg);
    else passes++;
    cycle(1'b1, 1'b1);
    checks++;
    if (Count !== 4'd14 || WriteReg !== 4'd1)
      $display("FAIL full_both2: got cnt=%0d wreg=%0d want 14/1", Count, WriteReg);
    else passes++;
    $display("full both: cnt=%0d wreg=%0d", Count, WriteReg);
  endtask

  task automatic test_empty_both();
    do_reset();
    cycle(1'b1, 1'b1);
    checks++;
    if (Count !== 4'd1 || WriteReg !== 4'd1 || Empty !== 1'b0)
      $display("FAIL empty_both: got cnt=%0d wreg=%0d empty=%b want 1/1/0", Count, WriteReg, Empty);
    else passes++;
    do_reset();
    cycle(1'b0, 1'b1);
    checks++;
    if (Count !== 4'd0 || Empty !== 1'b1 || WriteReg !== 4'd0)
      $display("FAIL empty_read: got cnt=%0d empty=%b wreg=%0d want 0/1/0", Count, Empty, WriteReg);
    else passes++;
    $display("empty both/read: cnt=%0d empty=%b", Count, Empty);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    WriteEn = 1'b0;
    checks++;
    if (Count !== 4'd7 || WriteReg !== 4'd7)
      $display("FAIL pre_async: got cnt=%0d wreg=%0d want 7/7", Count, WriteReg);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Count !== 4'd0 || Empty !== 1'b1 || WriteReg !== 4'd0 || Overflow !== 1'b0)
      $display("FAIL async_reset: got cnt=%0d empty=%b wreg=%0d ovf=%b want 0/1/0/0",
               Count, Empty, WriteReg, Overflow);
    else passes++;
    #2;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0);
    checks++;
    if (Count !== 4'd1 || WriteReg !== 4'd1)
      $display("FAIL post_async: got cnt=%0d wreg=%0d want 1/1", Count, WriteReg);
    else passes++;
    $display("async reset: cnt=%0d wreg=%0d", Count, WriteReg);
  endtask

  task automatic test_wrap_init14();
    do_reset();
    checks++;
    if (wreg14 !== 4'd14) $display("FAIL init14_reset: got %0d want 14", wreg14);
    else passes++;
    we14 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wreg14 !== 4'd0 || count14 !== 4'd1) $display("FAIL init14_wrap: got wreg=%0d cnt=%0d want 0/1", wreg14, count14);
    else passes++;
    @(posedge clk);
    #1;
    we14 = 1'b0;
    checks++;
    if (wreg14 !== 4'd1 || count14 !== 4'd2) $display("FAIL init14_next: got wreg=%0d cnt=%0d want 1/2", wreg14, count14);
    else passes++;
    $display("init14 wrap: wreg=%0d cnt=%0d", wreg14, count14);
  endtask

  task automatic test_random();
    bit we, re;
    int errs = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      // Alternate write-heavy and read-heavy phases so both Full and Empty are visited.
      if ((n / 50) % 2 == 0) begin
        we = ($urandom_range(0, 9) < 8);
        re = ($urandom_range(0, 9) < 3);
      end else begin
        we = ($urandom_range(0, 9) < 3);
        re = ($urandom_range(0, 9) < 8);
      end
      WriteEn = we;
      ReadEn  = re;
      #1;
      checks++;
      if (WriteAccept !== (we && m_count < 15)) begin
        errs++;
        $display("FAIL rand_accept[%0d]: got %b want %b", n, WriteAccept, we && m_count < 15);
      end else passes++;
      cycle(we, re);
      checks++;
      if ({WriteReg, Count, Full, Empty, Overflow} !==
          {4'(m_addr), 4'(m_count), m_count == 15, m_count == 0, m_ovf}) begin
        errs++;
        $display("FAIL rand_state[%0d]: got wreg=%0d cnt=%0d full=%b empty=%b ovf=%b want %0d/%0d/%b/%b/%b",
                 n, WriteReg, Count, Full, Empty, Overflow,
                 m_addr, m_count, m_count == 15, m_count == 0, m_ovf);
      end else passes++;
    end
    $display("random: 400 cycles, %0d errors, final cnt=%0d wreg=%0d", errs, Count, WriteReg);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_write();
    test_full_both();
    test_empty_both();
    test_async_reset();
    test_wrap_init14();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
